// File: rtl/aging_priority_arbiter.sv
// aging_priority_arbiter: registered, handshaked dynamic-priority arbiter.
// The winner is the highest effective priority among active requests, with
// ties broken round-robin from the rr pointer. A grant is held until the
// consumer accepts it (ready) or the requester withdraws.
//
// Optional aging boost is enabled by defining AGING_PRIORITY_ARBITER_AGING_EN.
// When it is defined, a requester that has waited AGE_THRESHOLD cycles gets a
// boost bit placed above its priority. When it is undefined, AGE_WIDTH and
// AGE_THRESHOLD are only range-checked.
//
// Ports:
//   clock        in   rising-edge clock
//   resetn       in   synchronous active-low reset
//   requests     in   [SIZE]            level request per requester
//   priorities   in   [PRIORITIES_WIDTH] priority i at [i*PRIORITY_WIDTH +: PRIORITY_WIDTH]
//   ready        in   consumer accepts the current grant this cycle
//   grant        out  [SIZE]            one-hot registered grant
//   grant_valid  out  |grant
//   grant_index  out  [INDEX_WIDTH]     binary index of grant (0 when idle)
module aging_priority_arbiter #(
  parameter int unsigned SIZE             = 4,
  parameter int unsigned PRIORITY_WIDTH   = 2,
  parameter int unsigned PRIORITIES_WIDTH = PRIORITY_WIDTH * SIZE,
  parameter int unsigned INDEX_WIDTH      = $clog2(SIZE),
  parameter int unsigned AGE_WIDTH        = 4,
  parameter int unsigned AGE_THRESHOLD    = 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [SIZE-1:0]             requests,
  input  logic [PRIORITIES_WIDTH-1:0] priorities,
  input  logic                        ready,
  output logic [SIZE-1:0]             grant,
  output logic                        grant_valid,
  output logic [INDEX_WIDTH-1:0]      grant_index
);

  // The effective priority is {boost, priority}. The boost bit is always
  // present and is tied low when aging is compiled out.
  localparam int unsigned EFF_WIDTH     = PRIORITY_WIDTH + 1;
  localparam int unsigned PTR_SUM_WIDTH = INDEX_WIDTH + 1;

  // Parameter legality checks at elaboration time.
  if (SIZE < 2) begin : g_bad_size
    $error("aging_priority_arbiter: SIZE must be at least 2");
  end
  if (AGE_THRESHOLD < 1 || AGE_THRESHOLD >= (1 << AGE_WIDTH)) begin : g_bad_threshold
    $error("aging_priority_arbiter: AGE_THRESHOLD out of range for AGE_WIDTH");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [INDEX_WIDTH-1:0]   rr_ptr;
  logic [INDEX_WIDTH-1:0]   rr_ptr_next;
  logic [SIZE-1:0]          grant_next;
  logic                     grant_valid_next;
  logic [INDEX_WIDTH-1:0]   grant_index_next;

  logic                     held_request;
  logic                     handshake;
  logic                     withdraw;
  logic                     rearbitrate;
  logic [INDEX_WIDTH-1:0]   served_ptr;
  logic [INDEX_WIDTH-1:0]   arb_ptr;

  logic [SIZE-1:0]          boost;
  logic [EFF_WIDTH-1:0]     eff [SIZE];

  logic                     win_found;
  logic [INDEX_WIDTH-1:0]   win_index;
  logic [EFF_WIDTH-1:0]     arb_best;
  logic [PTR_SUM_WIDTH-1:0] arb_pos;
  logic [INDEX_WIDTH-1:0]   arb_cand;

  // Decode the handshake and withdraw events of the held grant.
  assign held_request = requests[grant_index];
  assign handshake    = (state == GRANT) && held_request && ready;
  assign withdraw     = (state == GRANT) && !held_request;
  assign rearbitrate  = (state == IDLE) || handshake || withdraw;

  // A served grant moves the pointer one past the winner. Re-arbitration in
  // the same cycle already uses that advanced pointer.
  assign served_ptr = (grant_index == INDEX_WIDTH'(SIZE - 1)) ? '0
                                                              : grant_index + INDEX_WIDTH'(1);
  assign arb_ptr    = handshake ? served_ptr : rr_ptr;

`ifdef AGING_PRIORITY_ARBITER_AGING_EN
  localparam logic [AGE_WIDTH-1:0] AGE_MAX   = '1;
  localparam logic [AGE_WIDTH-1:0] AGE_BOOST = AGE_WIDTH'(AGE_THRESHOLD);

  logic [AGE_WIDTH-1:0] age [SIZE];

  // Per-requester wait counters. They count up while the requester waits,
  // saturate at the maximum, and clear when the requester is served or drops.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!resetn || !requests[i]) begin
        age[i] <= '0;
      end else if (handshake && (grant_index == INDEX_WIDTH'(i))) begin
        age[i] <= '0;
      end else if (age[i] != AGE_MAX) begin
        age[i] <= age[i] + AGE_WIDTH'(1);
      end
    end
  end

  always_comb begin
    boost = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      boost[i] = (age[i] >= AGE_BOOST);
    end
  end
`else
  assign boost = '0;
`endif

  // Build the effective priority. The requester served this cycle competes
  // without its boost, because its age is about to clear.
  always_comb begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      eff[i] = {boost[i] && !(handshake && (grant_index == INDEX_WIDTH'(i))),
                priorities[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]};
    end
  end

  // Scan the requesters starting at the pointer. Only a strictly greater
  // priority replaces the current best, so a tie goes to the requester the
  // scan reaches first.
  always_comb begin
    win_found = 1'b0;
    win_index = '0;
    arb_best  = '0;
    arb_pos   = '0;
    arb_cand  = '0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      arb_pos = {1'b0, arb_ptr} + PTR_SUM_WIDTH'(k);
      if (arb_pos >= PTR_SUM_WIDTH'(SIZE)) begin
        arb_pos = arb_pos - PTR_SUM_WIDTH'(SIZE);
      end
      arb_cand = arb_pos[INDEX_WIDTH-1:0];
      if (requests[arb_cand] && (!win_found || (eff[arb_cand] > arb_best))) begin
        win_found = 1'b1;
        win_index = arb_cand;
        arb_best  = eff[arb_cand];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
    end else begin
      state       <= state_next;
      rr_ptr      <= rr_ptr_next;
      grant       <= grant_next;
      grant_valid <= grant_valid_next;
      grant_index <= grant_index_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (rearbitrate) begin
      state_next = win_found ? GRANT : IDLE;
    end
  end

  // Next grant and pointer. The grant is held unless it was served or withdrawn.
  always_comb begin
    grant_next       = grant;
    grant_valid_next = grant_valid;
    grant_index_next = grant_index;
    rr_ptr_next      = rr_ptr;
    if (handshake) begin
      rr_ptr_next = served_ptr;
    end
    if (rearbitrate) begin
      grant_next       = win_found ? (SIZE'(1) << win_index) : '0;
      grant_valid_next = win_found;
      grant_index_next = win_found ? win_index : '0;
    end
  end

endmodule

// File: tb/tb_aging_priority_arbiter.sv
// tb_aging_priority_arbiter: scoreboard bench for aging_priority_arbiter.
// The stimulus runs directed scenarios and then random traffic. For every
// cycle it pushes the response expected from a rule-level reference model.
// A separate monitor pops one entry per cycle, compares it with the DUT
// outputs, and checks the structural invariants.
module tb_aging_priority_arbiter;

  localparam int SIZE    = 4;
  localparam int PW      = 2;
  localparam int AW      = 4;
  localparam int ATH     = 8;
  localparam int AGE_MAX = (1 << AW) - 1;
`ifdef AGING_PRIORITY_ARBITER_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic       clock      = 1'b0;
  logic       resetn     = 1'b0;
  logic       ready      = 1'b0;
  logic [3:0] requests   = 4'b0;
  logic [7:0] priorities = 8'b0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_index;

  aging_priority_arbiter #(
    .SIZE(SIZE), .PRIORITY_WIDTH(PW), .AGE_WIDTH(AW), .AGE_THRESHOLD(ATH)
  ) dut (
    .clock(clock), .resetn(resetn), .requests(requests), .priorities(priorities),
    .ready(ready), .grant(grant), .grant_valid(grant_valid), .grant_index(grant_index)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
  } exp_t;

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  bit   started = 1'b0;
  bit   done    = 1'b0;
  bit   seen_g1 = 1'b0;

  // Reference model state: current winner (-1 = none), rr pointer, wait ages.
  int m_g   = -1;
  int m_ptr = 0;
  int m_age [SIZE];

  // Highest effective priority wins; among equals, the first found walking from ptr.
  function automatic int pick(input logic [3:0] req, input logic [7:0] pri,
                              input int ptr, input int served);
    int eff [SIZE];
    int best = -1;
    for (int i = 0; i < SIZE; i++) begin
      eff[i] = 0;
      if (req[i]) begin
        eff[i] = int'(pri[i*PW +: PW]);
        if (AGING && m_age[i] >= ATH && i != served) eff[i] += (1 << PW);
        if (eff[i] > best) best = eff[i];
      end
    end
    for (int k = 0; k < SIZE; k++) begin
      int j;
      j = (ptr + k) % SIZE;
      if (req[j] && eff[j] == best) return j;
    end
    return -1;
  endfunction

  // Advance the model by one clock, using the inputs sampled at that edge.
  function automatic void model_step(input logic [3:0] req, input logic [7:0] pri,
                                     input logic rdy, input logic rst_n);
    int served;
    bit rearb;
    if (!rst_n) begin
      m_g   = -1;
      m_ptr = 0;
      for (int i = 0; i < SIZE; i++) m_age[i] = 0;
    end else begin
      served = -1;
      rearb  = 1'b0;
      if (m_g < 0) begin
        rearb = 1'b1;
      end else if (!req[m_g]) begin
        rearb = 1'b1;
      end else if (rdy) begin
        served = m_g;
        m_ptr  = (m_g + 1) % SIZE;
        rearb  = 1'b1;
      end
      if (rearb) m_g = pick(req, pri, m_ptr, served);
      for (int i = 0; i < SIZE; i++) begin
        if (!req[i] || i == served) m_age[i] = 0;
        else if (m_age[i] < AGE_MAX) m_age[i] = m_age[i] + 1;
      end
    end
  endfunction

  // Apply one cycle of inputs and push the response expected after the next edge.
  task automatic drive(input logic [3:0] req, input logic [7:0] pri,
                       input logic rdy, input logic rst_n);
    exp_t e;
    @(negedge clock);
    requests   = req;
    priorities = pri;
    ready      = rdy;
    resetn     = rst_n;
    model_step(req, pri, rdy, rst_n);
    e.v   = (m_g >= 0);
    e.g   = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
    e.idx = (m_g >= 0) ? 2'(m_g) : 2'b0;
    q.push_back(e);
    started = 1'b1;
  endtask

  task automatic repeat_drive(input int n, input logic [3:0] req, input logic [7:0] pri,
                              input logic rdy);
    for (int i = 0; i < n; i++) drive(req, pri, rdy, 1'b1);
  endtask

  // Monitor: one output sample per cycle, compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (grant == 4'b0010) seen_g1 = 1'b1;
        n_cmp++;
        if (grant !== e.g) begin
          n_bad++;
          $display("FAIL grant t=%0t got %b want %b", $time, grant, e.g);
        end
        n_cmp++;
        if (grant_index !== e.idx) begin
          n_bad++;
          $display("FAIL grant_index t=%0t got %0d want %0d", $time, grant_index, e.idx);
        end
        n_cmp++;
        if (grant_valid !== e.v) begin
          n_bad++;
          $display("FAIL grant_valid t=%0t got %b want %b", $time, grant_valid, e.v);
        end
        n_cmp++;
        if ($countones(grant) > 1 || grant_valid !== (|grant) || (grant & ~requests) != 4'b0) begin
          n_bad++;
          $display("FAIL invariant t=%0t grant %b valid %b requests %b", $time, grant,
                   grant_valid, requests);
        end
      end else if (started && !done) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty t=%0t got no expected entry", $time);
      end
    end
  end

  initial begin
    logic [3:0] r_req;
    logic [7:0] r_pri;
    for (int i = 0; i < SIZE; i++) m_age[i] = 0;

    // Reset.
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    drive(4'b0000, 8'h00, 1'b0, 1'b0);

    // Single request, back-to-back accepts.
    repeat_drive(4, 4'b0100, 8'h00, 1'b1);

    // Static priorities (p0 highest), then p1 raised to tie with p0.
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    repeat_drive(6, 4'b1111, 8'h1B, 1'b1);
    repeat_drive(6, 4'b1111, 8'h1F, 1'b1);

    // Aging: low-priority requester 1 must break through only when aging is on.
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    seen_g1 = 1'b0;
    repeat_drive(12, 4'b0011, 8'h03, 1'b1);
    @(posedge clock);
    #2;
    n_cmp++;
    if (seen_g1 !== AGING) begin
      n_bad++;
      $display("FAIL aging_breakthrough got %b want %b", seen_g1, AGING);
    end

    // Hold while a higher priority appears, then withdraw.
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    repeat_drive(2, 4'b0010, 8'h00, 1'b0);
    repeat_drive(5, 4'b1010, 8'hC0, 1'b0);
    repeat_drive(2, 4'b1000, 8'hC0, 1'b0);

    // Equal priorities rotate round-robin.
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    repeat_drive(6, 4'b1111, 8'h55, 1'b1);

    // Reset during a held grant restarts the pointer at 0.
    drive(4'b0000, 8'h00, 1'b0, 1'b0);
    repeat_drive(3, 4'b0100, 8'h00, 1'b0);
    drive(4'b0100, 8'h00, 1'b0, 1'b0);
    repeat_drive(3, 4'b1111, 8'h00, 1'b1);

    // Random traffic with persistent requests and occasional resets.
    r_req = 4'b0;
    r_pri = 8'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) r_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) r_pri = 8'($urandom_range(0, 255));
      drive(r_req, r_pri, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) != 0));
    end

    // Let the monitor drain the scoreboard, with a bounded wait.
    done = 1'b1;
    for (int w = 0; w < 10 && q.size() != 0; w++) @(posedge clock);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d entries left want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
